// File: rtl/automata_pkg.sv
// Shared types and default widths for the cellular-automaton frame memory arbiter.
package automata_pkg;

    localparam int ADDR_W_DEF   = 16;
    localparam int DATA_W_DEF   = 20;
    localparam int MAX_WAIT_DEF = 8;

    typedef enum logic [1:0] {
        NONE,
        DISP,
        ENG
    } owner_t;

    typedef enum logic {
        RUN,
        WAIT_SWAP
    } eng_state_t;

endpackage

// File: rtl/frame_bank_arbiter_starve_counter.sv
// Saturating counter with clear; flags when the engine has waited MAX cycles.
module starve_counter #(
    parameter int MAX = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int W = $clog2(MAX + 1);
    localparam logic [W-1:0] MAX_C = W'(MAX);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX_C)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max = (cnt_q == MAX_C);

endmodule

// File: rtl/frame_bank_arbiter.sv
// Frame RAM port arbiter between VGA scanout and the automaton engine, owning
// the front/back bank bit and swapping banks only at frame start.
module frame_bank_arbiter
    import automata_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              disp_req,
    input  logic [ADDR_W-2:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              eng_req,
    input  logic              eng_we,
    input  logic [ADDR_W-2:0] eng_addr,
    input  logic [DATA_W-1:0] eng_wdata,
    output logic              eng_gnt,
    output logic              eng_rvalid,
    output logic [DATA_W-1:0] eng_rdata,
    input  logic              eng_gen_done,
    output logic              gen_ack,
    output logic              front_bank,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q
);

    eng_state_t        state_q, state_d;
    logic              front_bank_q, front_bank_d;
    logic              gen_ack_q, gen_ack_d;
    owner_t            owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              eng_elig;
    logic              wait_max;

    starve_counter #(
        .MAX (MAX_WAIT)
    ) u_starve (
        .clk    (clk),
        .reset  (reset),
        .inc    (eng_elig && !eng_gnt),
        .clr    (!eng_req || eng_gnt),
        .at_max (wait_max)
    );

    // Grants are gated by reset so nothing reaches the RAM while the block is held.
    always_comb begin
        eng_elig = eng_req && (state_q == RUN);
        eng_gnt  = !reset && eng_elig && (!disp_req || wait_max);
        disp_gnt = !reset && disp_req && !eng_gnt;
        mem_we   = eng_gnt && eng_we;

        addr_d  = addr_q;
        wdata_d = wdata_q;
        owner_d = NONE;
        if (disp_gnt) begin
            addr_d  = {front_bank_q, disp_addr};
            owner_d = DISP;
        end else if (eng_gnt) begin
            addr_d = {front_bank_q ^ eng_we, eng_addr};
            if (eng_we) begin
                wdata_d = eng_wdata;
            end else begin
                owner_d = ENG;
            end
        end

        mem_address = reset ? '0 : addr_d;
        mem_wdata   = reset ? '0 : wdata_d;
    end

    always_comb begin
        state_d      = state_q;
        front_bank_d = front_bank_q;
        gen_ack_d    = 1'b0;
        case (state_q)
            RUN: begin
                if (eng_gen_done) begin
                    state_d = WAIT_SWAP;
                end
            end
            WAIT_SWAP: begin
                if (frame_start) begin
                    state_d      = RUN;
                    front_bank_d = !front_bank_q;
                    gen_ack_d    = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            front_bank_q <= 1'b0;
            gen_ack_q    <= 1'b0;
            owner_q      <= NONE;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            front_bank_q <= front_bank_d;
            gen_ack_q    <= gen_ack_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // Read data returns one cycle after grant; a reset in that cycle drops it.
    always_comb begin
        disp_rvalid = !reset && (owner_q == DISP);
        eng_rvalid  = !reset && (owner_q == ENG);
        disp_rdata  = disp_rvalid ? mem_q : '0;
        eng_rdata   = eng_rvalid ? mem_q : '0;
    end

    assign front_bank = front_bank_q;
    assign gen_ack    = gen_ack_q;

endmodule

// File: tb/tb_frame_bank_arbiter.sv
// Randomized and directed bench for frame_bank_arbiter against a behavioural model.
module tb_frame_bank_arbiter;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 20;
    localparam int MAX_WAIT = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              frame_start = 1'b0;
    logic              disp_req = 1'b0;
    logic [ADDR_W-2:0] disp_addr = '0;
    logic              eng_req = 1'b0;
    logic              eng_we = 1'b0;
    logic [ADDR_W-2:0] eng_addr = '0;
    logic [DATA_W-1:0] eng_wdata = '0;
    logic              eng_gen_done = 1'b0;
    logic [DATA_W-1:0] mem_q = '0;

    logic              disp_gnt, disp_rvalid, eng_gnt, eng_rvalid;
    logic              gen_ack, front_bank, mem_we;
    logic [DATA_W-1:0] disp_rdata, eng_rdata, mem_wdata;
    logic [ADDR_W-1:0] mem_address;

    frame_bank_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_start  (frame_start),
        .disp_req     (disp_req),
        .disp_addr    (disp_addr),
        .disp_gnt     (disp_gnt),
        .disp_rvalid  (disp_rvalid),
        .disp_rdata   (disp_rdata),
        .eng_req      (eng_req),
        .eng_we       (eng_we),
        .eng_addr     (eng_addr),
        .eng_wdata    (eng_wdata),
        .eng_gnt      (eng_gnt),
        .eng_rvalid   (eng_rvalid),
        .eng_rdata    (eng_rdata),
        .eng_gen_done (eng_gen_done),
        .gen_ack      (gen_ack),
        .front_bank   (front_bank),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_q        (mem_q)
    );

    always #5 clk = ~clk;

    // Registered-read RAM standing in for frame memory port B.
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    initial begin
        for (int a = 0; a < (1 << ADDR_W); a++) ram[a] <= DATA_W'($urandom);
    end
    always @(posedge clk) begin
        if (mem_we) ram[mem_address] <= mem_wdata;
        mem_q <= ram[mem_address];
    end

    int n_vec = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state: what the block should be holding right now.
    bit                m_wait_swap = 0;
    bit                m_bank = 0;
    bit                m_ack = 0;
    int                m_wcnt = 0;
    int                m_pend = 0;       // 0 none, 1 display read, 2 engine read
    logic [ADDR_W-1:0] m_sh_addr = '0;
    logic [DATA_W-1:0] m_sh_wdata = '0;
    logic [DATA_W-1:0] m_rdata = '0;

    bit                o_dg, o_eg, o_we, o_drv, o_erv, o_fb, o_ack;
    logic [ADDR_W-1:0] o_addr;

    task automatic tick();
        bit                e_eg, e_dg, e_we, e_drv, e_erv, elig;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wdata, e_drd, e_erd;
        #3;
        elig = 0; e_eg = 0; e_dg = 0; e_we = 0; e_drv = 0; e_erv = 0;
        e_addr = '0; e_wdata = '0; e_drd = '0; e_erd = '0;
        if (!reset) begin
            elig = eng_req && !m_wait_swap;
            e_eg = elig && (!disp_req || m_wcnt == MAX_WAIT);
            e_dg = disp_req && !e_eg;
            e_we = e_eg && eng_we;
            e_addr = m_sh_addr;
            e_wdata = m_sh_wdata;
            if (e_dg) e_addr = {m_bank, disp_addr};
            else if (e_eg) e_addr = {m_bank ^ eng_we, eng_addr};
            if (e_we) e_wdata = eng_wdata;
            e_drv = (m_pend == 1);
            e_erv = (m_pend == 2);
            if (e_drv) e_drd = m_rdata;
            if (e_erv) e_erd = m_rdata;
        end
        chk("disp_gnt", disp_gnt, e_dg);
        chk("eng_gnt", eng_gnt, e_eg);
        chk("mem_we", mem_we, e_we);
        chk("mem_address", mem_address, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("disp_rvalid", disp_rvalid, e_drv);
        chk("eng_rvalid", eng_rvalid, e_erv);
        chk("disp_rdata", disp_rdata, e_drd);
        chk("eng_rdata", eng_rdata, e_erd);
        chk("front_bank", front_bank, m_bank);
        chk("gen_ack", gen_ack, m_ack);
        o_dg = disp_gnt; o_eg = eng_gnt; o_we = mem_we; o_addr = mem_address;
        o_drv = disp_rvalid; o_erv = eng_rvalid; o_fb = front_bank; o_ack = gen_ack;

        if (reset) begin
            m_wait_swap = 0; m_bank = 0; m_ack = 0; m_wcnt = 0; m_pend = 0;
            m_sh_addr = '0; m_sh_wdata = '0;
        end else begin
            if (!eng_req || e_eg) m_wcnt = 0;
            else if (elig && m_wcnt < MAX_WAIT) m_wcnt++;
            m_ack = 0;
            if (!m_wait_swap) begin
                if (eng_gen_done) m_wait_swap = 1;
            end else if (frame_start) begin
                m_wait_swap = 0;
                m_bank = ~m_bank;
                m_ack = 1;
            end
            m_pend = e_dg ? 1 : ((e_eg && !eng_we) ? 2 : 0);
            if (m_pend != 0) m_rdata = ram[e_addr];
            m_sh_addr = e_addr;
            m_sh_wdata = e_wdata;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_req = 0; eng_req = 0; eng_we = 0; frame_start = 0; eng_gen_done = 0;
    endtask

    initial begin
        int cnt;
        reset = 1;
        @(posedge clk);
        #1;
        tick();
        reset = 0;
        idle();
        tick();
        chk("rst_front_bank", o_fb, 0);
        chk("rst_gen_ack", o_ack, 0);
        chk("rst_mem_address", o_addr, 0);

        // Display-only traffic
        disp_req = 1; disp_addr = 15'h0100;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("disp_only_addr", o_addr, 16'h0100);
            chk("disp_only_gnt", o_dg, 1);
            if (i > 0) chk("disp_only_rvalid", o_drv, 1);
        end
        idle();
        tick();
        chk("disp_last_rvalid", o_drv, 1);

        // Engine write into the back bank
        eng_req = 1; eng_we = 1; eng_addr = 15'h0005; eng_wdata = 20'hABCDE;
        tick();
        chk("eng_wr_addr", o_addr, 16'h8005);
        chk("eng_wr_we", o_we, 1);
        idle();
        tick();
        chk("eng_wr_no_drv", o_drv, 0);
        chk("eng_wr_no_erv", o_erv, 0);

        // Both requesting: engine forced through every MAX_WAIT+1 cycles
        disp_req = 1; eng_req = 1; eng_we = 0;
        cnt = 0;
        for (int i = 0; i < 90; i++) begin
            disp_addr = 15'($urandom); eng_addr = 15'($urandom);
            tick();
            chk("starve_eng_gnt", o_eg, (i % 9) == 8);
            chk("starve_disp_gnt", o_dg, (i % 9) != 8);
            cnt += o_eg;
        end
        chk("starve_eng_total", cnt, 10);
        idle();
        tick();

        // Generation done, swap 50 cycles later
        eng_req = 1; eng_gen_done = 1;
        tick();
        eng_gen_done = 0;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            cnt += o_eg;
        end
        chk("swap_wait_eng_gnts", cnt, 0);
        frame_start = 1;
        tick();
        chk("swap_cycle_front_bank", o_fb, 0);
        frame_start = 0;
        tick();
        chk("swap_front_bank", o_fb, 1);
        chk("swap_gen_ack", o_ack, 1);
        chk("swap_eng_resume", o_eg, 1);
        tick();
        chk("swap_gen_ack_pulse", o_ack, 0);

        // gen_done coincident with frame_start: defer to the next frame
        eng_gen_done = 1; frame_start = 1;
        tick();
        eng_gen_done = 0; frame_start = 0;
        tick();
        chk("coinc_no_swap", o_fb, 1);
        chk("coinc_no_ack", o_ack, 0);
        chk("coinc_eng_held", o_eg, 0);
        repeat (5) tick();
        frame_start = 1;
        tick();
        frame_start = 0;
        tick();
        chk("coinc_late_swap", o_fb, 0);
        chk("coinc_late_ack", o_ack, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            disp_req     = ($urandom_range(0, 3) != 0);
            disp_addr    = 15'($urandom);
            eng_req      = ($urandom_range(0, 2) != 0);
            eng_we       = $urandom_range(0, 1);
            eng_addr     = 15'($urandom_range(0, 63));
            eng_wdata    = 20'($urandom);
            eng_gen_done = ($urandom_range(0, 39) == 0);
            frame_start  = ($urandom_range(0, 59) == 0);
            reset        = ($urandom_range(0, 299) == 0);
            tick();
        end
        idle();
        reset = 0;

        // Reset right after an engine read grant, from front_bank=1
        reset = 1;
        tick();
        reset = 0;
        eng_gen_done = 1;
        tick();
        eng_gen_done = 0; frame_start = 1;
        tick();
        frame_start = 0;
        tick();
        chk("pre_rst_front_bank", o_fb, 1);
        eng_req = 1; eng_we = 0; eng_addr = 15'h0123;
        tick();
        chk("pre_rst_eng_gnt", o_eg, 1);
        idle();
        reset = 1;
        tick();
        chk("rst_suppress_erv", o_erv, 0);
        reset = 0;
        tick();
        chk("post_rst_front_bank", o_fb, 0);
        chk("post_rst_gen_ack", o_ack, 0);
        chk("post_rst_erv", o_erv, 0);
        chk("post_rst_drv", o_drv, 0);
        chk("post_rst_mem_we", o_we, 0);
        chk("post_rst_mem_address", o_addr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/frame_bank_arbiter.md
# frame_bank_arbiter

Shares the single frame-memory port between two requesters and sequences double-buffered generation swaps for the cellular-automaton display. The two requesters are:
- the VGA scanout reader, which is latency-critical;
- the automaton update engine, which reads the current generation and writes the next.

The block sits between `VGA_LED_Emulator`, the automaton engine and the 20-bit-wide frame RAM port B. It owns the front/back bank bit, which is memory address MSB. Swaps happen only at a frame boundary, so a half-updated generation is never displayed.

## Interface
Parameters:
- `ADDR_W`, 16, memory address width; MSB is the bank bit.
- `DATA_W`, 20, memory word width.
- `MAX_WAIT`, 8, consecutive cycles an engine request may be denied before it is forced through.

Ports:
- `clk`  in  1  single clock (108 MHz pixel clock domain).
- `reset`  in  1  synchronous, active-high.
- `frame_start`  in  1  one-cycle pulse at start of vertical blanking.
- `disp_req`  in  1  display read request.
- `disp_addr`  in  ADDR_W-1  display word address within a bank.
- `disp_gnt`  out  1  display request accepted this cycle.
- `disp_rvalid`  out  1  display read data valid.
- `disp_rdata`  out  DATA_W  display read data.
- `eng_req`  in  1  engine request.
- `eng_we`  in  1  1 = write to back bank, 0 = read from front bank.
- `eng_addr`  in  ADDR_W-1  engine word address within a bank.
- `eng_wdata`  in  DATA_W  engine write data.
- `eng_gnt`  out  1  engine request accepted this cycle.
- `eng_rvalid`  out  1  engine read data valid.
- `eng_rdata`  out  DATA_W  engine read data.
- `eng_gen_done`  in  1  pulse: engine finished writing the next generation.
- `gen_ack`  out  1  pulse: swap performed, engine may start the next generation.
- `front_bank`  out  1  current display bank.
- `mem_address`  out  ADDR_W  RAM address.
- `mem_wdata`  out  DATA_W  RAM write data.
- `mem_we`  out  1  RAM write enable.
- `mem_q`  in  DATA_W  RAM read data, registered, 1-cycle latency.

## Operation
**Engine state machine**, two states:
- RUN: engine requests are eligible for grant.
  - `eng_gen_done` moves the FSM to WAIT_SWAP.
- WAIT_SWAP: `eng_gnt` is held 0.
  - `eng_gen_done` is ignored.
  - On `frame_start`, the block toggles `front_bank`, pulses `gen_ack` for one cycle, and returns to RUN.
- If `eng_gen_done` and `frame_start` arrive in the same cycle while in RUN, the FSM enters WAIT_SWAP. It swaps at the next `frame_start`, never the current one.

**Arbitration**, at most one grant per cycle, combinational from the current-cycle requests:
- Display wins by default.
- The engine wins if the display is not requesting, or if `wait_cnt == MAX_WAIT` while `eng_req` is high and the FSM is in RUN.
- `wait_cnt` behaviour:
  - increments when the engine is eligible but denied, saturating at `MAX_WAIT`;
  - clears on an engine grant, or when `eng_req` is low.

**Addressing:**
- Display read: `mem_address = {front_bank, disp_addr}`.
- Engine read: `{front_bank, eng_addr}`.
- Engine write: `{~front_bank, eng_addr}`, with `mem_we=1` and `mem_wdata=eng_wdata`.
- No grant: `mem_we=0`; `mem_address` and `mem_wdata` hold their last value (registered shadow).

**Read return:**
- The owner tag of a granted read is registered.
- On the next cycle, exactly one of `disp_rvalid`/`eng_rvalid` is 1, and its rdata equals `mem_q`.
- Writes produce no rvalid.

## Timing
- Reset values: FSM=RUN, `front_bank`=0, `wait_cnt`=0, `gen_ack`=0, both rvalid=0, `mem_we`=0, `mem_address`=0, `mem_wdata`=0, rdata=0.
- Grant latency is 0 cycles; read-data latency is 1 cycle after the grant.
- Reset asserted in the cycle after a granted read suppresses that read's rvalid.
- `front_bank` changes on the clock edge that samples `frame_start` in WAIT_SWAP; `gen_ack` is high the following cycle.
- Display reads granted in the swap cycle use the old bank.
- Worst-case engine wait is `MAX_WAIT+1` cycles; worst-case display stall is 1 cycle per `MAX_WAIT+1`.

## Structure
- Package `automata_pkg`:
  - `ADDR_W`/`DATA_W` defaults;
  - `owner_t` enum (NONE, DISP, ENG);
  - `eng_state_t` enum (RUN, WAIT_SWAP).
- No sub-module is required. The optional `starve_counter` (saturating counter with clear) is the only natural split.

## Test plan
- Display only, `disp_addr`=0x0100, `front_bank`=0:
  - expect `mem_address`=0x0100 and `disp_gnt`=1 each cycle;
  - expect `disp_rvalid` one cycle later with `mem_q` data.
- Engine write `eng_addr`=0x0005 with `front_bank`=0, no display traffic:
  - expect `mem_address`=0x8005, `mem_we`=1;
  - expect no rvalid.
- Display and engine requesting continuously, `MAX_WAIT`=8:
  - expect the engine granted once every 9 cycles;
  - expect the display stalled exactly on those cycles.
- Engine `eng_gen_done`, then `frame_start` 50 cycles later:
  - expect `eng_gnt`=0 during the wait;
  - expect `front_bank` toggles 0→1, `gen_ack` pulses once, and engine grants resume.
- `eng_gen_done` coincident with `frame_start`: expect no swap at that frame, swap at the next `frame_start`.
- Reset asserted the cycle after an engine read grant: expect `eng_rvalid`=0 and all outputs at reset values.
